feature_packer: RTL

FEATURE_PACKER -- requirements
Module: feature_packer

---
 rtl/feature_packer_if.sv | 20 ++
 rtl/feature_packer.sv | 105 ++++++++++
 2 files changed

// File: rtl/feature_packer_if.sv
// Handshake bundle for feature_packer: raw sample stream in, packed 44-bit vector out.
interface feature_packer_if;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [43:0] m_data;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/feature_packer.sv
// Packs 11 quantised 4-bit features into one 44-bit vector and checks frame framing.
// Optional macro FEAT_CLAMP_EN selects saturating clamp instead of upper-nibble truncation.
module feature_packer (
  input  logic             clk,
  input  logic             rst,
  feature_packer_if.slave  bus,
  output logic             err,
  output logic [15:0]      frame_cnt
);

  typedef enum logic [0:0] {StFill, StLast} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [39:0] asm_q, asm_d;
  logic [43:0] mdata_q, mdata_d;
  logic        mvalid_q, mvalid_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  feat;
  logic        s_fire, m_fire;

`ifdef FEAT_CLAMP_EN
  assign feat = (bus.s_data > 8'd15) ? 4'd15 : bus.s_data[3:0];
`else
  logic unused_low_bits;
  assign feat            = bus.s_data[7:4];
  assign unused_low_bits = ^bus.s_data[3:0];
`endif

  // Only a held vector blocks the frame-completing sample; fill slots never stall.
  assign bus.s_ready = !(state_q == StLast && mvalid_q && !bus.m_ready);
  assign s_fire      = bus.s_valid && bus.s_ready;
  assign m_fire      = mvalid_q && bus.m_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    if (m_fire) begin
      mvalid_d = 1'b0;
      cnt_d    = cnt_q + 16'd1;
    end

    if (s_fire) begin
      unique case (state_q)
        StFill: begin
          if (bus.s_last) begin
            idx_d = 4'd0;
            err_d = 1'b1;
          end else begin
            asm_d[{idx_q, 2'b00} +: 4] = feat;
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd9) state_d = StLast;
          end
        end
        StLast: begin
          if (bus.s_last) begin
            mdata_d  = {feat, asm_q};
            mvalid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          idx_d   = 4'd0;
          state_d = StFill;
        end
        default: begin
          idx_d   = 4'd0;
          state_d = StFill;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFill;
      idx_q    <= 4'd0;
      asm_q    <= 40'd0;
      mdata_q  <= 44'd0;
      mvalid_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      asm_q    <= asm_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.m_valid = mvalid_q;
  assign bus.m_data  = mdata_q;
  assign err         = err_q;
  assign frame_cnt   = cnt_q;

endmodule
